// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for the UART RX word path.
package uart_pkg;

  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned BAUD         = 9600;
  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchronizer, mid-bit sampling FSM and baud counter.
// Produces a one-cycle byte_done on a good stop bit, frame_err on a bad one.
module uart_rx #(
  parameter int unsigned BAUD_CNT_MAX = uart_pkg::BAUD_CNT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       frame_err
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2 - 1);

  logic             rx_s1;
  logic             rx_s2;
  logic             rx_d;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             mid_tick;
  logic             start_edge;

  assign mid_tick   = (baud_cnt == CNT_MID);
  assign start_edge = rx_d & ~rx_s2;
  assign byte_data  = shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start_edge) state_next = START;
      // A line that is high again at mid-start was only a glitch.
      START: if (mid_tick) state_next = rx_s2 ? IDLE : DATA;
      DATA:  if (mid_tick && (bit_idx == 3'd7)) state_next = STOP;
      STOP:  if (mid_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;

      byte_done <= (state == STOP) && mid_tick && rx_s2;
      frame_err <= (state == STOP) && mid_tick && !rx_s2;

      // Held at zero in IDLE so it starts from 0 on entry to START.
      if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (baud_cnt == CNT_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == START) begin
        bit_idx <= '0;
      end else if ((state == DATA) && mid_tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs received UART byte pairs (first byte low) into 16-bit FIFO writes,
// with flush of an odd byte and a sticky overflow flag for dropped words.
module uart_rx_word_packer #(
  parameter int unsigned CLK_FREQ     = uart_pkg::CLK_FREQ,
  parameter int unsigned BAUD         = uart_pkg::BAUD,
  parameter int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        wr_full,
  input  logic        flush,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        ovf
);
  import uart_pkg::*;

  logic [7:0] byte_data;
  logic       byte_done;
  logic       half;
  logic [7:0] lo_byte;

  uart_rx #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_data(byte_data),
    .byte_done(byte_done),
    .frame_err(frame_err)
  );

  // byte_done takes priority; a coincident flush is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half       <= 1'b0;
      lo_byte    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_done) begin
        if (!half) begin
          lo_byte <= byte_data;
          half    <= 1'b1;
        end else begin
          half <= 1'b0;
          if (!wr_full) begin
            word_data  <= {byte_data, lo_byte};
            word_valid <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
      end else if (flush && half) begin
        half <= 1'b0;
        if (!wr_full) begin
          word_data  <= {8'h00, lo_byte};
          word_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer with a scaled-down bit period.
module tb_uart_rx_word_packer;

  localparam int unsigned BCM = 50;
  localparam int unsigned BIT = 49;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_full = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        ovf;

  int checks = 0;
  int passes = 0;
  int fe_count = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_word;
  } vec_t;
  vec_t vecs[4];

  uart_rx_word_packer #(.BAUD_CNT_MAX(BCM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .wr_full   (wr_full),
    .flush     (flush),
    .word_data (word_data),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every word_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_count++;
    if (word_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {16'h0, word_data}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {16'h0, word_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (200_000) @(negedge clk);
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h34, 8'h12, 16'h1234};
    vecs[1] = '{8'hA5, 8'h5A, 16'h5AA5};
    vecs[2] = '{8'h00, 8'hFF, 16'hFF00};
    vecs[3] = '{8'hFF, 8'h01, 16'h01FF};

    repeat (5) @(negedge clk);
    chk("rst_word_data", {16'h0, word_data}, 32'h0);
    chk("rst_word_valid", {31'h0, word_valid}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      send_byte(vecs[v].b0, 1'b1);
      exp_q.push_back(vecs[v].exp_word);
      send_byte(vecs[v].b1, 1'b1);
      wait_drain("pair_drain");
    end
    chk("pairs_ovf", {31'h0, ovf}, 32'h0);

    // Short low glitch: rejected at mid-start, no frame error, packer untouched.
    rx = 1'b0;
    repeat (BCM / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BCM) @(negedge clk);
    chk("glitch_frame_err", fe_count, 0);

    // Bad stop bit, then a normal pair.
    send_byte(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    chk("stop_err_count", fe_count, 1);
    send_byte(8'h34, 1'b1);
    exp_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    wait_drain("after_err_drain");

    // Second byte while FIFO full: word dropped, ovf sticky.
    send_byte(8'h78, 1'b1);
    wr_full = 1'b1;
    send_byte(8'h56, 1'b1);
    wr_full = 1'b0;
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    repeat (10_000) @(negedge clk);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);

    // Odd byte flushed, then a flush with nothing pending.
    send_byte(8'hAB, 1'b1);
    exp_q.push_back(16'h00AB);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", {31'h0, word_valid}, 32'h1);
    chk("flush_data", {16'h0, word_data}, 32'h0000_00AB);
    wait_drain("flush_drain");
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_empty_valid", {31'h0, word_valid}, 32'h0);

    // Pending low byte plus a partial frame, both lost to a one-cycle reset.
    send_byte(8'h99, 1'b1);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_word_data", {16'h0, word_data}, 32'h0);
    chk("mid_rst_word_valid", {31'h0, word_valid}, 32'h0);
    chk("mid_rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
    repeat (2 * BCM) @(negedge clk);
    send_byte(8'hCD, 1'b1);
    exp_q.push_back(16'hEFCD);
    send_byte(8'hEF, 1'b1);
    wait_drain("final_drain");
    chk("final_frame_errs", fe_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Receives 8N1 RS232 bytes on `rx`, checks framing, and packs byte pairs into 16-bit words for the SDRAM write FIFO inside `uart_sdram_top`. It sits between the board `rx` pin and the FIFO write port that feeds the SDRAM write burst logic. The first byte received is the low byte. A sticky flag reports words dropped because the FIFO was full.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock in Hz.
- `BAUD`, default 9600: serial bit rate.
- `BAUD_CNT_MAX`, default CLK_FREQ/BAUD (5208): clocks per bit.

Ports:
- `clk`  in  1  system clock, 50 MHz. Single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous serial input; idles high.
- `wr_full`  in  1  SDRAM write FIFO full.
- `flush`  in  1  one-cycle pulse; emits a pending odd byte.
- `word_data`  out  16  packed word as {second byte, first byte}.
- `word_valid`  out  1  one-cycle FIFO write enable.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `ovf`  out  1  sticky: a word was dropped because `wr_full` was high.

## Operation
- `rx` passes through a 2-FF synchronizer plus a third delay flop. A start edge is a falling edge on the delayed pair while in IDLE.
- Receiver FSM states and transitions:
  - IDLE -> START on a start edge.
  - START -> DATA if `rx` samples 0 at mid-bit (count == BAUD_CNT_MAX/2-1). If it samples 1, the edge was a glitch: return to IDLE.
  - DATA samples 8 bits at mid-bit, LSB first, then moves to STOP.
  - STOP samples at mid-bit:
    - 1: `byte_done` pulses and the FSM returns to IDLE immediately, so back-to-back frames are accepted.
    - 0: `frame_err` pulses for one cycle, the byte is discarded, and the FSM returns to IDLE.
- The baud counter runs 0..BAUD_CNT_MAX-1, wraps at the end of each bit, and clears on entry to START.
- Packer holds `half` (a low byte is pending) and `lo_byte`:
  - On `byte_done` with `half`=0: store the byte in `lo_byte`, set `half`.
  - On `byte_done` with `half`=1: form {byte, lo_byte} and clear `half`. If `wr_full`=0, drive `word_valid`=1 for one cycle. Otherwise drop the word and set `ovf`.
  - On `flush` with `half`=1: emit {8'h00, lo_byte} under the same full rule and clear `half`. `flush` with `half`=0 does nothing.
  - If `flush` and `byte_done` coincide, `byte_done` is processed and `flush` is ignored.
- `ovf` is cleared only by reset.
- `word_data` holds its last value between pulses. It is valid only while `word_valid`=1.

## Timing
- Reset values: `word_data`=16'h0000, `word_valid`=0, `frame_err`=0, `ovf`=0. Internally, FSM=IDLE, `half`=0, all counters 0, synchronizer flops=1.
- Start detection: 3 clk after the falling edge of `rx`.
- `byte_done`: mid-stop sample, about 9.5 bit times + 3 clk after the start edge.
- `word_valid`: registered, asserted the cycle after the second `byte_done`.
- `flush` response: `word_valid` asserts the cycle after `flush`.
- `wr_full` is sampled in the same cycle as `byte_done`/`flush`.
- Bit-rate tolerance: ±2% (the bench uses 5207 clk per bit).
- Reset asserted mid-frame: everything returns to reset values on the next clock edge, and any partial byte or word is lost.

## Structure
- Package `uart_pkg` holds:
  - `CLK_FREQ`, `BAUD`, `BAUD_CNT_MAX`;
  - the receiver state enum (IDLE, START, DATA, STOP).
- Sub-module `uart_rx` contains the synchronizer, FSM and baud counter, and outputs `byte_data[7:0]` and `byte_done`.
- The packer, `ovf` and `flush` logic live in the top module `uart_rx_word_packer`.

## Test plan
- Bytes 0x34 then 0x12 at 5207 clk/bit -> exactly one `word_valid` pulse, `word_data`=16'h1234, `ovf`=0.
- `rx` low for 1000 clk, then high -> no `byte_done`, no `word_valid`, `frame_err`=0.
- Byte 0x55 sent with stop bit 0 -> one `frame_err` pulse, packer not advanced. Then 0x34, 0x12 -> word 16'h1234.
- 0x78 with `wr_full`=0, then 0x56 with `wr_full`=1 -> no `word_valid`, `ovf`=1, still 1 after 10k clk.
- Byte 0xAB, then a `flush` pulse -> `word_valid` next cycle with `word_data`=16'h00AB. A second `flush` -> no pulse.
- `rst_n` low for one clk in the middle of the DATA bits of byte 0x11 -> all outputs 0. Then 0xCD, 0xEF -> word 16'hEFCD.
